// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Wishbone read master that walks a
// sequential PC, buffers results in a 2-entry prefetch FIFO for decode,
// supports redirects from execute and reports bus errors/timeouts as faults.
module fetch_unit #(
   parameter int                   ADR_WIDTH = 48,
   parameter int                   DAT_WIDTH = 64,
   parameter logic [ADR_WIDTH-1:0] RESET_PC  = 48'h800000000000,
   parameter int                   TIMEOUT   = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic [ADR_WIDTH-1:0] fetch_adr_o,
   input  logic [DAT_WIDTH-1:0] fetch_dat_i,
   output logic                 fetch_stb_o,
   output logic                 fetch_cyc_o,
   output logic                 fetch_we_o,
   input  logic                 fetch_ack_i,
   input  logic                 fetch_err_i,
   input  logic                 redirect_i,
   input  logic [ADR_WIDTH-1:0] redirect_pc_i,
   output logic [DAT_WIDTH-1:0] instr_o,
   output logic [ADR_WIDTH-1:0] instr_pc_o,
   output logic                 instr_valid_o,
   input  logic                 instr_ready_i,
   output logic                 fault_o,
   output logic [ADR_WIDTH-1:0] fault_pc_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP,
      FAULT
   } state_t;

   state_t                 state_q, state_d;
   logic [ADR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADR_WIDTH-1:0]   adr_q, adr_d;
   logic                   discard_q, discard_d;
   logic [TW-1:0]          tmoCount_q, tmoCount_d;
   logic [ADR_WIDTH-1:0]   faultPc_q, faultPc_d;
   logic [1:0]             fifoCount_q, fifoCount_d;
   logic [DAT_WIDTH-1:0]   headInstr_q, headInstr_d;
   logic [ADR_WIDTH-1:0]   headPc_q, headPc_d;
   logic [DAT_WIDTH-1:0]   tailInstr_q, tailInstr_d;
   logic [ADR_WIDTH-1:0]   tailPc_q, tailPc_d;

   logic                   push;
   logic                   pop;
   logic                   tmoHit;
   logic [ADR_WIDTH-1:0]   redirectPc;
   logic [2:0]             unusedPcBits;

   // Redirect targets are forced onto an 8-byte boundary; the low bits are dropped.
   assign redirectPc   = {redirect_pc_i[ADR_WIDTH-1:3], 3'b000};
   assign unusedPcBits = redirect_pc_i[2:0];
   assign tmoHit       = (tmoCount_q == TW'(TIMEOUT - 1));
   assign pop          = instr_ready_i && (fifoCount_q != 2'd0);

   // Fetch sequencing: issue, wait for ack/err/timeout, mandatory low gap, fault.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      adr_d      = adr_q;
      discard_d  = discard_q;
      tmoCount_d = tmoCount_q;
      faultPc_d  = faultPc_q;
      push       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!redirect_i && (fifoCount_q < 2'd2)) begin
               state_d    = REQ;
               adr_d      = pc_q;
               tmoCount_d = '0;
            end
         end
         REQ: begin
            if (fetch_ack_i) begin
               if (!redirect_i && !discard_q) begin
                  push = 1'b1;
                  pc_d = adr_q + ADR_WIDTH'(8);
               end
               discard_d = 1'b0;
               state_d   = GAP;
            end else if (fetch_err_i || tmoHit) begin
               if (redirect_i || discard_q) begin
                  state_d = GAP;
               end else begin
                  faultPc_d = adr_q;
                  state_d   = FAULT;
               end
               discard_d = 1'b0;
            end else begin
               tmoCount_d = tmoCount_q + TW'(1);
               if (redirect_i) begin
                  discard_d = 1'b1;
               end
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         FAULT: begin
            if (redirect_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect_i) begin
         pc_d = redirectPc;
      end
   end

   // Prefetch FIFO: head/tail registers, a redirect flush overrides push and pop.
   always_comb begin
      fifoCount_d = fifoCount_q;
      headInstr_d = headInstr_q;
      headPc_d    = headPc_q;
      tailInstr_d = tailInstr_q;
      tailPc_d    = tailPc_q;

      if (redirect_i) begin
         fifoCount_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifoCount_q == 2'd0) begin
                  headInstr_d = fetch_dat_i;
                  headPc_d    = adr_q;
               end else begin
                  tailInstr_d = fetch_dat_i;
                  tailPc_d    = adr_q;
               end
               fifoCount_d = fifoCount_q + 2'd1;
            end
            2'b01: begin
               headInstr_d = tailInstr_q;
               headPc_d    = tailPc_q;
               fifoCount_d = fifoCount_q - 2'd1;
            end
            2'b11: begin
               if (fifoCount_q == 2'd1) begin
                  headInstr_d = fetch_dat_i;
                  headPc_d    = adr_q;
               end else begin
                  headInstr_d = tailInstr_q;
                  headPc_d    = tailPc_q;
                  tailInstr_d = fetch_dat_i;
                  tailPc_d    = adr_q;
               end
            end
            default: begin
               fifoCount_d = fifoCount_q;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         adr_q       <= RESET_PC;
         discard_q   <= 1'b0;
         tmoCount_q  <= '0;
         faultPc_q   <= '0;
         fifoCount_q <= 2'd0;
         headInstr_q <= '0;
         headPc_q    <= '0;
         tailInstr_q <= '0;
         tailPc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         adr_q       <= adr_d;
         discard_q   <= discard_d;
         tmoCount_q  <= tmoCount_d;
         faultPc_q   <= faultPc_d;
         fifoCount_q <= fifoCount_d;
         headInstr_q <= headInstr_d;
         headPc_q    <= headPc_d;
         tailInstr_q <= tailInstr_d;
         tailPc_q    <= tailPc_d;
      end
   end

   // While a strobe is up the latched request address is shown, otherwise the next PC.
   assign fetch_adr_o   = (state_q == REQ) ? adr_q : pc_q;
   assign fetch_stb_o   = (state_q == REQ);
   assign fetch_cyc_o   = (state_q == REQ);
   assign fetch_we_o    = 1'b0;
   assign instr_o       = headInstr_q;
   assign instr_pc_o    = headPc_q;
   assign instr_valid_o = (fifoCount_q != 2'd0);
   assign fault_o       = (state_q == FAULT);
   assign fault_pc_o    = faultPc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a Wishbone ROM slave model and
// compares the instruction stream with a sequential-PC reference model.
module tb_fetch_unit;

   localparam int            AW        = 48;
   localparam int            DW        = 64;
   localparam logic [AW-1:0] BOOT_PC   = 48'h800000000000;
   localparam logic [DW-1:0] BOOT_WORD = 64'h0280401002000010;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] fetchAdr;
   logic [DW-1:0] fetchDat;
   logic          fetchStb;
   logic          fetchCyc;
   logic          fetchWe;
   logic          fetchAck;
   logic          fetchErr;
   logic          redirect;
   logic [AW-1:0] redirectPc;
   logic [DW-1:0] instr;
   logic [AW-1:0] instrPc;
   logic          instrValid;
   logic          instrReady;
   logic          fault;
   logic [AW-1:0] faultPc;

   int testsRun    = 0;
   int testsFailed = 0;

   // slave model configuration and state
   bit            randomWait = 1'b0;
   int            waitStates = 0;
   bit            mute       = 1'b0;
   bit            errEnable  = 1'b0;
   logic [AW-1:0] errAdr     = '0;
   int            slaveCnt   = 0;
   bit            prevStb    = 1'b0;
   bit            prevResp   = 1'b0;
   int            gapViol    = 0;

   // events observed by the most recent stimulus step
   bit            evIssue;
   logic [AW-1:0] evIssueAdr;
   bit            evPop;
   logic [AW-1:0] evPopPc;
   logic [DW-1:0] evPopData;
   bit            evErrDriven;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .fetch_adr_o   (fetchAdr),
      .fetch_dat_i   (fetchDat),
      .fetch_stb_o   (fetchStb),
      .fetch_cyc_o   (fetchCyc),
      .fetch_we_o    (fetchWe),
      .fetch_ack_i   (fetchAck),
      .fetch_err_i   (fetchErr),
      .redirect_i    (redirect),
      .redirect_pc_i (redirectPc),
      .instr_o       (instr),
      .instr_pc_o    (instrPc),
      .instr_valid_o (instrValid),
      .instr_ready_i (instrReady),
      .fault_o       (fault),
      .fault_pc_o    (faultPc)
   );

   // ROM contents: fixed boot word, every other address holds an address hash
   function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
      if (a == BOOT_PC) return BOOT_WORD;
      return {a[31:0] ^ 32'h5A5AC3C3, a[47:16] + 32'h13579BDF};
   endfunction

   // one cycle: observe DUT at negedge, run the slave, drive inputs for next posedge
   task automatic applyStimulus(input logic ready, input logic redir, input logic [AW-1:0] rpc);
      logic [DW-1:0] junk;
      @(negedge clk);
      evIssue     = fetchStb && !prevStb;
      evIssueAdr  = fetchAdr;
      evPop       = instrValid && ready && !redir;
      evPopPc     = instrPc;
      evPopData   = instr;
      evErrDriven = 1'b0;
      if (prevResp && prevStb && fetchStb) gapViol++;
      fetchAck = 1'b0;
      fetchErr = 1'b0;
      junk     = {$urandom, $urandom};
      fetchDat = junk;
      if (fetchStb) begin
         if (slaveCnt == 0 && randomWait) waitStates = $urandom_range(0, 3);
         slaveCnt++;
         if (!mute && slaveCnt >= 2 + waitStates) begin
            if (errEnable && fetchAdr == errAdr) begin
               fetchErr    = 1'b1;
               evErrDriven = 1'b1;
            end else begin
               fetchAck = 1'b1;
               fetchDat = romWord(fetchAdr);
            end
            slaveCnt = 0;
         end
      end else begin
         slaveCnt = 0;
      end
      prevStb    = fetchStb;
      prevResp   = fetchAck || fetchErr;
      instrReady = ready;
      redirect   = redir;
      redirectPc = rpc;
   endtask

   // step until the next strobe rising edge or the bound expires
   task automatic waitIssue(input int bound, input logic ready, output bit seen, output logic [AW-1:0] adr);
      seen = 1'b0;
      adr  = '0;
      for (int i = 0; i < bound && !seen; i++) begin
         applyStimulus(ready, 1'b0, '0);
         if (evIssue) begin
            seen = 1'b1;
            adr  = evIssueAdr;
         end
      end
   endtask

   // step with ready high until decode accepts an instruction or the bound expires
   task automatic waitPop(input int bound, output bit seen, output logic [AW-1:0] pc, output logic [DW-1:0] data);
      seen = 1'b0;
      pc   = '0;
      data = '0;
      for (int i = 0; i < bound && !seen; i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         if (evPop) begin
            seen = 1'b1;
            pc   = evPopPc;
            data = evPopData;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if ({fetchStb, fetchCyc, fetchWe, instrValid, fault} !== 5'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {fetchStb, fetchCyc, fetchWe, instrValid, fault});
      end
      testsRun++;
      if (fetchAdr !== BOOT_PC) begin
         testsFailed++;
         $display("[TB] FAIL reset_adr: got %h expected %h", fetchAdr, BOOT_PC);
      end
      testsRun++;
      if ({instrPc, faultPc} !== 96'h0 || instr !== 64'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_zero: got pc %h fpc %h instr %h expected all 0", instrPc, faultPc, instr);
      end
      rst = 1'b0;
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b0, '0);
         n++;
      end while (!fetchStb && n < 10);
      testsRun++;
      if (n !== 1 || fetchAdr !== BOOT_PC) begin
         testsFailed++;
         $display("[TB] FAIL first_req: got %0d cycles adr %h expected 1 cycle adr %h", n, fetchAdr, BOOT_PC);
      end
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (fetchStb !== 1'b1 || instrValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL ack_cycle: got stb %b valid %b expected 1 0", fetchStb, instrValid);
      end
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (fetchStb !== 1'b0 || instrValid !== 1'b1 || instr !== BOOT_WORD || instrPc !== BOOT_PC) begin
         testsFailed++;
         $display("[TB] FAIL gap_cycle: got stb %b valid %b instr %h pc %h expected 0 1 %h %h",
                  fetchStb, instrValid, instr, instrPc, BOOT_WORD, BOOT_PC);
      end
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (fetchStb !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL idle_cycle: got stb %b expected 0", fetchStb);
      end
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (fetchStb !== 1'b1 || fetchAdr !== BOOT_PC + 48'd8) begin
         testsFailed++;
         $display("[TB] FAIL second_req: got stb %b adr %h expected 1 %h", fetchStb, fetchAdr, BOOT_PC + 48'd8);
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] issued[$];
      logic [AW-1:0] popPcs[$];
      logic [DW-1:0] popData[$];
      logic [AW-1:0] resumeAdr;
      bit            resumed;
      randomWait = 1'b1;
      applyStimulus(1'b0, 1'b1, BOOT_PC);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b0, '0);
         if (evIssue) issued.push_back(evIssueAdr);
      end
      testsRun++;
      if (issued.size() !== 2) begin
         testsFailed++;
         $display("[TB] FAIL bp_count: got %0d fetches expected 2", issued.size());
      end else begin
         testsRun++;
         if (issued[0] !== BOOT_PC || issued[1] !== BOOT_PC + 48'd8) begin
            testsFailed++;
            $display("[TB] FAIL bp_adrs: got %h %h expected %h %h", issued[0], issued[1], BOOT_PC, BOOT_PC + 48'd8);
         end
      end
      testsRun++;
      if (fetchStb !== 1'b0 || instrValid !== 1'b1 || instrPc !== BOOT_PC) begin
         testsFailed++;
         $display("[TB] FAIL bp_hold: got stb %b valid %b pc %h expected 0 1 %h", fetchStb, instrValid, instrPc, BOOT_PC);
      end
      resumed = 1'b0;
      resumeAdr = '0;
      for (int i = 0; i < 30 && !(resumed && popPcs.size() >= 2); i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         if (evPop) begin
            popPcs.push_back(evPopPc);
            popData.push_back(evPopData);
         end
         if (evIssue && !resumed) begin
            resumed   = 1'b1;
            resumeAdr = evIssueAdr;
         end
      end
      testsRun++;
      if (popPcs.size() < 2) begin
         testsFailed++;
         $display("[TB] FAIL bp_drain: got %0d pops expected 2", popPcs.size());
      end else begin
         testsRun++;
         if (popPcs[0] !== BOOT_PC || popData[0] !== romWord(BOOT_PC) ||
             popPcs[1] !== BOOT_PC + 48'd8 || popData[1] !== romWord(BOOT_PC + 48'd8)) begin
            testsFailed++;
            $display("[TB] FAIL bp_order: got %h/%h %h/%h expected %h/%h %h/%h",
                     popPcs[0], popData[0], popPcs[1], popData[1],
                     BOOT_PC, romWord(BOOT_PC), BOOT_PC + 48'd8, romWord(BOOT_PC + 48'd8));
         end
      end
      testsRun++;
      if (!resumed || resumeAdr !== BOOT_PC + 48'h10) begin
         testsFailed++;
         $display("[TB] FAIL bp_resume: got seen %b adr %h expected 1 %h", resumed, resumeAdr, BOOT_PC + 48'h10);
      end
   endtask

   task automatic test_redirect_mid();
      localparam logic [AW-1:0] TARGET = 48'h800000000080;
      bit            seen;
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
      int            held;
      int            popsBefore;
      bit            adrMoved;
      bit            faultSeen;
      bit            validAfter;
      randomWait = 1'b0;
      waitStates = 3;
      applyStimulus(1'b1, 1'b1, BOOT_PC);
      waitIssue(40, 1'b1, seen, adr);
      testsRun++;
      if (!seen || adr !== BOOT_PC) begin
         testsFailed++;
         $display("[TB] FAIL rd_setup: got seen %b adr %h expected 1 %h", seen, adr, BOOT_PC);
      end
      applyStimulus(1'b1, 1'b1, TARGET);
      held = 0;
      popsBefore = 0;
      adrMoved = 1'b0;
      faultSeen = 1'b0;
      validAfter = 1'b1;
      seen = 1'b0;
      adr = '0;
      for (int i = 0; i < 20 && !seen; i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         if (i == 0) validAfter = instrValid;
         if (evIssue) begin
            seen = 1'b1;
            adr  = evIssueAdr;
         end else if (fetchStb) begin
            held++;
            if (fetchAdr !== BOOT_PC) adrMoved = 1'b1;
         end
         if (evPop) popsBefore++;
         if (fault) faultSeen = 1'b1;
      end
      testsRun++;
      if (validAfter !== 1'b0 || popsBefore !== 0) begin
         testsFailed++;
         $display("[TB] FAIL rd_flush: got valid %b pops %0d expected 0 0", validAfter, popsBefore);
      end
      testsRun++;
      if (held !== 3 || adrMoved) begin
         testsFailed++;
         $display("[TB] FAIL rd_hold: got %0d held cycles moved %b expected 3 0", held, adrMoved);
      end
      testsRun++;
      if (!seen || adr !== TARGET || faultSeen) begin
         testsFailed++;
         $display("[TB] FAIL rd_newadr: got seen %b adr %h fault %b expected 1 %h 0", seen, adr, faultSeen, TARGET);
      end
      waitPop(20, seen, adr, data);
      testsRun++;
      if (!seen || adr !== TARGET || data !== romWord(TARGET)) begin
         testsFailed++;
         $display("[TB] FAIL rd_pop: got %b %h %h expected 1 %h %h", seen, adr, data, TARGET, romWord(TARGET));
      end
   endtask

   task automatic test_bus_error();
      localparam logic [AW-1:0] TARGET = 48'h800000000078;
      bit            seen;
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
      int            errStep;
      int            faultStep;
      int            stbCount;
      bit            faultDropped;
      randomWait = 1'b0;
      waitStates = 0;
      errEnable  = 1'b1;
      errAdr     = BOOT_PC + 48'h10;
      applyStimulus(1'b0, 1'b1, BOOT_PC);
      repeat (25) applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (!evPop || evPopPc !== BOOT_PC || evPopData !== romWord(BOOT_PC)) begin
         testsFailed++;
         $display("[TB] FAIL be_first: got %b %h %h expected 1 %h %h", evPop, evPopPc, evPopData, BOOT_PC, romWord(BOOT_PC));
      end
      errStep = -1;
      faultStep = -1;
      for (int i = 0; i < 20 && faultStep < 0; i++) begin
         applyStimulus(1'b0, 1'b0, '0);
         if (fault) faultStep = i;
         if (evErrDriven && errStep < 0) errStep = i;
      end
      testsRun++;
      if (errStep < 0 || faultStep !== errStep + 1 || faultPc !== BOOT_PC + 48'h10) begin
         testsFailed++;
         $display("[TB] FAIL be_fault: got err@%0d fault@%0d fpc %h expected fault one after err, fpc %h",
                  errStep, faultStep, faultPc, BOOT_PC + 48'h10);
      end
      stbCount = 0;
      faultDropped = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, '0);
         if (fetchStb) stbCount++;
         if (!fault) faultDropped = 1'b1;
      end
      testsRun++;
      if (stbCount !== 0 || faultDropped || instrValid !== 1'b1 || instrPc !== BOOT_PC + 48'd8) begin
         testsFailed++;
         $display("[TB] FAIL be_sticky: got stb %0d dropped %b valid %b pc %h expected 0 0 1 %h",
                  stbCount, faultDropped, instrValid, instrPc, BOOT_PC + 48'd8);
      end
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (!evPop || evPopPc !== BOOT_PC + 48'd8 || evPopData !== romWord(BOOT_PC + 48'd8)) begin
         testsFailed++;
         $display("[TB] FAIL be_drain: got %b %h %h expected 1 %h %h", evPop, evPopPc, evPopData,
                  BOOT_PC + 48'd8, romWord(BOOT_PC + 48'd8));
      end
      applyStimulus(1'b0, 1'b0, '0);
      testsRun++;
      if (instrValid !== 1'b0 || fault !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL be_empty: got valid %b fault %b expected 0 1", instrValid, fault);
      end
      applyStimulus(1'b0, 1'b1, TARGET);
      applyStimulus(1'b0, 1'b0, '0);
      testsRun++;
      if (fault !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL be_clear: got fault %b expected 0", fault);
      end
      waitIssue(20, 1'b1, seen, adr);
      testsRun++;
      if (!seen || adr !== TARGET) begin
         testsFailed++;
         $display("[TB] FAIL be_refetch: got %b %h expected 1 %h", seen, adr, TARGET);
      end
      waitPop(20, seen, adr, data);
      testsRun++;
      if (!seen || adr !== TARGET || data !== romWord(TARGET)) begin
         testsFailed++;
         $display("[TB] FAIL be_pop: got %b %h %h expected 1 %h %h", seen, adr, data, TARGET, romWord(TARGET));
      end
      errEnable = 1'b0;
   endtask

   task automatic test_timeout();
      localparam logic [AW-1:0] TARGET = 48'h800000000100;
      bit            seen;
      logic [AW-1:0] adr;
      int            reqCycles;
      mute = 1'b1;
      applyStimulus(1'b1, 1'b1, TARGET);
      waitIssue(60, 1'b1, seen, adr);
      testsRun++;
      if (!seen || adr !== TARGET) begin
         testsFailed++;
         $display("[TB] FAIL to_issue: got %b %h expected 1 %h", seen, adr, TARGET);
      end
      reqCycles = 1;
      for (int i = 0; i < 40 && !fault; i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         if (fetchStb) reqCycles++;
      end
      testsRun++;
      if (reqCycles !== 15 || fault !== 1'b1 || faultPc !== TARGET || fetchStb !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL to_fault: got %0d cycles fault %b fpc %h stb %b expected 15 1 %h 0",
                  reqCycles, fault, faultPc, fetchStb, TARGET);
      end
      mute = 1'b0;
      applyStimulus(1'b1, 1'b1, BOOT_PC);
      applyStimulus(1'b1, 1'b0, '0);
      testsRun++;
      if (fault !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL to_clear: got fault %b expected 0", fault);
      end
   endtask

   task automatic test_misaligned_wrap();
      localparam logic [AW-1:0] TOP = 48'hFFFFFFFFFFF8;
      bit            seen;
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
      randomWait = 1'b1;
      applyStimulus(1'b1, 1'b1, 48'h800000000025);
      waitIssue(40, 1'b1, seen, adr);
      testsRun++;
      if (!seen || adr !== 48'h800000000020) begin
         testsFailed++;
         $display("[TB] FAIL mis_adr: got %b %h expected 1 800000000020", seen, adr);
      end
      waitPop(20, seen, adr, data);
      testsRun++;
      if (!seen || adr !== 48'h800000000020 || data !== romWord(48'h800000000020)) begin
         testsFailed++;
         $display("[TB] FAIL mis_pop: got %b %h %h expected 1 800000000020 %h", seen, adr, data, romWord(48'h800000000020));
      end
      applyStimulus(1'b0, 1'b1, TOP);
      waitIssue(40, 1'b0, seen, adr);
      testsRun++;
      if (!seen || adr !== TOP) begin
         testsFailed++;
         $display("[TB] FAIL wrap_top: got %b %h expected 1 %h", seen, adr, TOP);
      end
      waitIssue(20, 1'b0, seen, adr);
      testsRun++;
      if (!seen || adr !== 48'h0) begin
         testsFailed++;
         $display("[TB] FAIL wrap_zero: got %b %h expected 1 000000000000", seen, adr);
      end
      waitPop(20, seen, adr, data);
      testsRun++;
      if (!seen || adr !== TOP || data !== romWord(TOP)) begin
         testsFailed++;
         $display("[TB] FAIL wrap_pop0: got %b %h %h expected 1 %h %h", seen, adr, data, TOP, romWord(TOP));
      end
      waitPop(20, seen, adr, data);
      testsRun++;
      if (!seen || adr !== 48'h0 || data !== romWord(48'h0)) begin
         testsFailed++;
         $display("[TB] FAIL wrap_pop1: got %b %h %h expected 1 0 %h", seen, adr, data, romWord(48'h0));
      end
   endtask

   task automatic test_random_stream();
      logic [AW-1:0] expNext;
      logic [63:0]   r;
      logic [AW-1:0] rpc;
      logic          ready;
      logic          redir;
      int            pops;
      bit            faultSeen;
      randomWait = 1'b1;
      r = {$urandom, $urandom};
      rpc = r[AW-1:0];
      applyStimulus(1'b1, 1'b1, rpc);
      expNext = {rpc[AW-1:3], 3'b000};
      pops = 0;
      faultSeen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         ready = ($urandom_range(0, 1) == 1);
         redir = ($urandom_range(0, 49) == 0);
         r = {$urandom, $urandom};
         rpc = r[AW-1:0];
         applyStimulus(ready, redir, rpc);
         if (fault) faultSeen = 1'b1;
         if (evPop) begin
            pops++;
            testsRun++;
            if (evPopPc !== expNext || evPopData !== romWord(expNext)) begin
               testsFailed++;
               $display("[TB] FAIL stream_pop: got %h/%h expected %h/%h", evPopPc, evPopData, expNext, romWord(expNext));
            end
            expNext = expNext + 48'd8;
         end
         if (redir) expNext = {rpc[AW-1:3], 3'b000};
      end
      testsRun++;
      if (pops < 30 || faultSeen) begin
         testsFailed++;
         $display("[TB] FAIL stream_progress: got %0d pops fault %b expected >=30 0", pops, faultSeen);
      end
   endtask

   // bound on total simulated time in case the DUT stops responding
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // test sequence
   initial begin
      rst        = 1'b1;
      fetchDat   = '0;
      fetchAck   = 1'b0;
      fetchErr   = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;
      instrReady = 1'b0;
      test_reset();
      test_backpressure();
      test_redirect_mid();
      test_bus_error();
      test_timeout();
      test_misaligned_wrap();
      test_random_stream();
      testsRun++;
      if (gapViol !== 0) begin
         testsFailed++;
         $display("[TB] FAIL gap_rule: got %0d strobes held across an ack expected 0", gapViol);
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
